// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | hazard_scoreboard_unit: LC-3b decode-side pending-write scoreboard, fetch    |
// | request FSM and pipeline load-enable merge. Option macro: HAZARD_BYPASS_EN.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module hazard_scoreboard_unit #(
  parameter int NUM_REGS = 8,
  parameter int NUM_SRC  = 3,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16,
  parameter int REG_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic [NUM_SRC*REG_W-1:0] src_reg,
  input  logic                     dest_used,
  input  logic [REG_W-1:0]         dest_reg,
  input  logic                     ret_valid,
  input  logic [REG_W-1:0]         ret_reg,
  input  logic                     cancel_valid,
  input  logic [REG_W-1:0]         cancel_reg,
  input  logic                     imem_resp,
  input  logic                     dmem_read,
  input  logic                     dmem_write,
  input  logic                     dmem_resp,
  input  logic                     dmem_multi,
  output logic                     imem_read,
  output logic                     load_pc,
  output logic                     load_de,
  output logic                     load_back,
  output logic                     insert_nop,
  output logic [STALL_W-1:0]       stall_cycles,
  output logic                     sb_error
);

  localparam logic [CNT_W-1:0]   C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   C_CNT_ONE = CNT_W'(1);
  localparam logic [STALL_W-1:0] C_STALL_MAX = '1;

  typedef enum logic [0:0] {
    F_REQ  = 1'b0,
    F_HOLD = 1'b1
  } fstate_t;

  fstate_t r_fstate;
  fstate_t w_fstate_nxt;

  logic [CNT_W-1:0]   r_pend [NUM_REGS];
  logic [CNT_W-1:0]   w_pend_nxt [NUM_REGS];
  logic [CNT_W:0]     w_up [NUM_REGS];
  logic [CNT_W:0]     w_dn [NUM_REGS];
  logic [CNT_W:0]     w_diff [NUM_REGS];
  logic [NUM_REGS-1:0] w_under;

  logic [STALL_W-1:0] r_stall;
  logic               r_sb_error;

  logic [NUM_SRC-1:0] w_src_haz;
  logic               w_dest_sat;
  logic               w_hazard;
  logic               w_mem_ok;
  logic               w_fetch_ok;
  logic               w_load_reg;
  logic               w_load_de;
  logic               w_commit;

  // Multi-access first responses keep the back end frozen; only the final one releases it.
  assign w_mem_ok   = !(dmem_read || dmem_write) || (dmem_resp && !dmem_multi);
  assign w_fetch_ok = imem_resp || (r_fstate == F_HOLD);
  assign w_load_reg = w_fetch_ok && w_mem_ok;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_W-1:0] w_sel;
      logic             w_byp;
      assign w_sel = src_reg[i*REG_W +: REG_W];
`ifdef HAZARD_BYPASS_EN
      assign w_byp = ret_valid && (ret_reg == w_sel) && (r_pend[w_sel] == C_CNT_ONE);
`else
      assign w_byp = 1'b0;
`endif
      assign w_src_haz[i] = src_used[i] && (r_pend[w_sel] != '0) && !w_byp;
    end
  endgenerate

  assign w_dest_sat = dest_used && (r_pend[dest_reg] == C_CNT_MAX);
  assign w_hazard   = issue_valid && ((|w_src_haz) || w_dest_sat);
  assign w_load_de  = w_load_reg && !w_hazard;
  assign w_commit   = w_load_de && issue_valid && dest_used;

  // Issue, retire and cancel are summed per register; a net result below zero clamps.
  always_comb begin
    w_under = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_up[r]   = {1'b0, r_pend[r]} + (CNT_W+1)'(w_commit && (dest_reg == REG_W'(r)));
      w_dn[r]   = (CNT_W+1)'(ret_valid && (ret_reg == REG_W'(r)))
                + (CNT_W+1)'(cancel_valid && (cancel_reg == REG_W'(r)));
      w_diff[r] = w_up[r] - w_dn[r];
      w_under[r] = (w_up[r] < w_dn[r]);
      w_pend_nxt[r] = w_under[r] ? '0 : w_diff[r][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pend[r] <= w_pend_nxt[r];
      end
    end
  end

  always_comb begin
    w_fstate_nxt = r_fstate;
    case (r_fstate)
      F_REQ:   if (imem_resp && !w_load_de) w_fstate_nxt = F_HOLD;
      F_HOLD:  if (w_load_de) w_fstate_nxt = F_REQ;
      default: w_fstate_nxt = F_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fstate   <= F_REQ;
      r_stall    <= '0;
      r_sb_error <= 1'b0;
    end else begin
      r_fstate   <= w_fstate_nxt;
      r_sb_error <= r_sb_error || (|w_under);
      if (!w_load_de && (r_stall != C_STALL_MAX)) begin
        r_stall <= r_stall + STALL_W'(1);
      end
    end
  end

  // Outputs are held low for as long as reset is asserted.
  assign imem_read    = rst_n && (r_fstate == F_REQ);
  assign load_pc      = rst_n && w_load_de;
  assign load_de      = rst_n && w_load_de;
  assign load_back    = rst_n && w_load_reg;
  assign insert_nop   = rst_n && w_hazard;
  assign stall_cycles = r_stall;
  assign sb_error     = r_sb_error;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_hazard_scoreboard_unit: directed vectors, expected values queued by the  |
// | stimulus and compared by a negedge monitor.                                 |
// | Revision: 1.1                                                               |
// +-----------------------------------------------------------------------------+
module tb_hazard_scoreboard_unit;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [2:0]  src_used;
    logic [8:0]  src_reg;
    logic        dest_used;
    logic [2:0]  dest_reg;
    logic        ret_valid;
    logic [2:0]  ret_reg;
    logic        cancel_valid;
    logic [2:0]  cancel_reg;
    logic        imem_resp;
    logic        dmem_read, dmem_write, dmem_resp, dmem_multi;
    logic        imem_read, load_pc, load_de, load_back, insert_nop;
    logic [15:0] stall_cycles;
    logic        sb_error;

    hazard_scoreboard_unit dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
        .src_used(src_used), .src_reg(src_reg),
        .dest_used(dest_used), .dest_reg(dest_reg),
        .ret_valid(ret_valid), .ret_reg(ret_reg),
        .cancel_valid(cancel_valid), .cancel_reg(cancel_reg),
        .imem_resp(imem_resp), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_resp(dmem_resp), .dmem_multi(dmem_multi),
        .imem_read(imem_read), .load_pc(load_pc), .load_de(load_de),
        .load_back(load_back), .insert_nop(insert_nop),
        .stall_cycles(stall_cycles), .sb_error(sb_error)
    );

    typedef struct {
        string       nm;
        logic [4:0]  o;    // {imem_read, load_pc, load_de, load_back, insert_nop}
        bit          chs;
        logic [15:0] st;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t m_x;
    logic [4:0] m_act;
    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_x   = q.pop_front();
            m_act = {imem_read, load_pc, load_de, load_back, insert_nop};
            n_chk++;
            if (m_act !== m_x.o || (m_x.chs && stall_cycles !== m_x.st) || sb_error !== m_x.err) begin
                n_fail++;
                $display("FAIL %s: got out=%b stall=%0d err=%b, want out=%b stall=%0d err=%b",
                         m_x.nm, m_act, stall_cycles, sb_error, m_x.o,
                         m_x.chs ? m_x.st : stall_cycles, m_x.err);
            end
        end
    end

    task automatic expect_o(input string nm, input bit ir, input bit lpc, input bit lde,
                            input bit lbk, input bit nop, input bit chs, input int st,
                            input bit err);
        exp_t e;
        e.nm = nm; e.o = {ir, lpc, lde, lbk, nop}; e.chs = chs; e.st = 16'(st); e.err = err;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string nm);
        #1;
        n_chk++;
        if ({imem_read, load_pc, load_de, load_back, insert_nop} !== 5'b0 ||
            stall_cycles !== 16'd0 || sb_error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s reset state: out=%b stall=%0d err=%b",
                     nm, {imem_read, load_pc, load_de, load_back, insert_nop},
                     stall_cycles, sb_error);
        end
    endtask

    task automatic wait_load_de(input string nm, input int max_cyc);
        int k;
        k = 0;
        while (load_de !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
        n_chk++;
        if (load_de !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: load_de not asserted within %0d cycles", nm, max_cyc);
        end
    endtask

    task automatic idle();
        issue_valid = 0; src_used = '0; src_reg = '0; dest_used = 0; dest_reg = '0;
        ret_valid = 0; ret_reg = '0; cancel_valid = 0; cancel_reg = '0;
        imem_resp = 1; dmem_read = 0; dmem_write = 0; dmem_resp = 0; dmem_multi = 0;
    endtask

    task automatic do_reset(input string nm);
        idle();
        rst_n = 0;
        check_reset_state(nm);
        expect_o(nm, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        rst_n = 1;
    endtask

    task automatic writer(input logic [2:0] r);
        idle(); issue_valid = 1; dest_used = 1; dest_reg = r;
    endtask

    task automatic reader(input int s, input logic [2:0] r);
        idle(); issue_valid = 1; src_used[s] = 1'b1; src_reg[s*3 +: 3] = r;
    endtask

    initial begin
        rst_n = 0;
        idle();
        tick();

        // reset release
        do_reset("in_reset");
        idle(); imem_resp = 0; expect_o("rel_noresp", 1, 0, 0, 0, 0, 1, 0, 0); tick();
        idle(); expect_o("rel_resp", 1, 1, 1, 1, 0, 1, 1, 0); tick();

        // RAW stall on R3
        do_reset("rst_raw");
        writer(3'd3); expect_o("raw_writer", 1, 1, 1, 1, 0, 1, 0, 0); tick();
        reader(0, 3'd3); expect_o("raw_stall0", 1, 0, 0, 1, 1, 1, 0, 0); tick();
        reader(0, 3'd3); expect_o("raw_stall1", 0, 0, 0, 1, 1, 1, 1, 0); tick();
`ifdef HAZARD_BYPASS_EN
        reader(0, 3'd3); ret_valid = 1; ret_reg = 3'd3;
        expect_o("raw_ret_byp", 0, 1, 1, 1, 0, 1, 2, 0); tick();
        idle(); expect_o("raw_after", 1, 1, 1, 1, 0, 1, 2, 0); tick();
`else
        reader(0, 3'd3); ret_valid = 1; ret_reg = 3'd3;
        expect_o("raw_ret", 0, 0, 0, 1, 1, 1, 2, 0); tick();
        reader(0, 3'd3); expect_o("raw_go", 0, 1, 1, 1, 0, 1, 3, 0); tick();
        idle(); expect_o("raw_after", 1, 1, 1, 1, 0, 1, 3, 0); tick();
`endif

        // three in-flight writers to R5, fourth saturates
        do_reset("rst_r5");
        writer(3'd5); tick();
        writer(3'd5); tick();
        writer(3'd5); tick();
        writer(3'd5); expect_o("r5_sat", 1, 0, 0, 1, 1, 1, 0, 0); tick();
        writer(3'd5); ret_valid = 1; ret_reg = 3'd5;
        expect_o("r5_sat_ret", 0, 0, 0, 1, 1, 1, 1, 0); tick();
        writer(3'd5); expect_o("r5_4th_issue", 0, 1, 1, 1, 0, 1, 2, 0); tick();
        reader(0, 3'd5); expect_o("r5_read_stall", 1, 0, 0, 1, 1, 0, 0, 0); tick();
        idle(); ret_valid = 1; ret_reg = 3'd5; tick();
        idle(); ret_valid = 1; ret_reg = 3'd5; tick();
        reader(2, 3'd5); expect_o("r5_read_p1", 1, 0, 0, 1, 1, 0, 0, 0); tick();
        idle(); ret_valid = 1; ret_reg = 3'd5; tick();
        reader(2, 3'd5); expect_o("r5_read_go", 1, 1, 1, 1, 0, 0, 0, 0); tick();

        // simultaneous events
        do_reset("rst_sim");
        writer(3'd2); tick();
        writer(3'd2); ret_valid = 1; ret_reg = 3'd2; tick();
        reader(0, 3'd2); expect_o("r2_net0_stall", 1, 0, 0, 1, 1, 0, 0, 0); tick();
        idle(); ret_valid = 1; ret_reg = 3'd2; tick();
        reader(0, 3'd2); expect_o("r2_clear", 1, 1, 1, 1, 0, 0, 0, 0); tick();
        writer(3'd1); tick();
        idle(); ret_valid = 1; ret_reg = 3'd1; cancel_valid = 1; cancel_reg = 3'd1;
        expect_o("r1_err_pre", 1, 1, 1, 1, 0, 0, 0, 0); tick();
        idle(); expect_o("r1_err_set", 1, 1, 1, 1, 0, 0, 0, 1); tick();
        reader(1, 3'd1); expect_o("r1_no_haz", 1, 1, 1, 1, 0, 0, 0, 1); tick();

        // memory stall with a multi-access first response
        do_reset("rst_mem");
        idle(); dmem_read = 1; expect_o("mem_wait", 1, 0, 0, 0, 0, 1, 0, 0); tick();
        idle(); dmem_read = 1; dmem_resp = 1; dmem_multi = 1;
        expect_o("mem_multi", 0, 0, 0, 0, 0, 1, 1, 0); tick();
        idle(); dmem_read = 1; expect_o("mem_wait2", 0, 0, 0, 0, 0, 1, 2, 0); tick();
        idle(); dmem_read = 1; dmem_resp = 1;
        expect_o("mem_final", 0, 1, 1, 1, 0, 1, 3, 0); tick();
        idle(); expect_o("mem_after", 1, 1, 1, 1, 0, 1, 3, 0); tick();

        // reset while in F_HOLD with two writers pending on R4
        do_reset("rst_r4");
        writer(3'd4); tick();
        writer(3'd4); tick();
        reader(0, 3'd4); expect_o("r4_stall", 1, 0, 0, 1, 1, 1, 0, 0); tick();
        do_reset("r4_mid_reset");
        reader(0, 3'd4); expect_o("r4_after_rst", 1, 1, 1, 1, 0, 1, 0, 0); tick();

        // bounded wait for a RAW hazard on R6 to resolve after its retire
        writer(3'd6); tick();
        reader(0, 3'd6); ret_valid = 1; ret_reg = 3'd6; tick();
        reader(0, 3'd6);
        wait_load_de("r6_wait", 4);
        tick();

        idle();
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
